mul_share_arbiter: RTL and testbench

//   Shares one sequential multiplier (datapath + controller pair) among N requesters.

---
 rtl/mul_share_pkg.sv | 23 ++
 rtl/mul_share_arbiter_rr_pick.sv | 39 +++
 rtl/mul_share_arbiter.sv | 143 ++++++++++++++
 tb/tb_mul_share_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing arbiter.
//   state_t : arbiter FSM encoding (3 bits)
//   id_w    : width of a requester index for N requesters
//   tmo_w   : width of a watchdog counter able to hold TMO
package mul_share_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_RDY  = 3'd3,
        DONE      = 3'd4
    } state_t;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int tmo_w(input int tmo);
        return $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/mul_share_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req     in  N      pending requesters
//   rr_ptr  in  ID_W   index where the search starts (wraps N-1 -> 0)
//   gnt_vld out 1      at least one requester pending
//   gnt_id  out ID_W   first pending index at or after rr_ptr
module rr_pick
    import mul_share_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [id_w(N)-1:0]   rr_ptr,
    output logic                 gnt_vld,
    output logic [id_w(N)-1:0]   gnt_id
);

    localparam int ID_W = id_w(N);

    // Walk the offsets from farthest to nearest so the nearest pending
    // requester is the one left standing.
    always_comb begin
        int s;
        logic [ID_W-1:0] idx;
        s       = 0;
        idx     = '0;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            s = int'(rr_ptr) + k;
            if (s >= N) s = s - N;
            idx = ID_W'(s);
            if (req[idx]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx;
            end
        end
    end

endmodule

// File: rtl/mul_share_arbiter.sv
// Shares one sequential multiplier among N requesters.
//   clk, reset        clock, synchronous active-high reset
//   req/ack           per-requester handshake; ack is a one-cycle one-hot pulse
//   opa_in/opb_in     packed operands, requester i in bits [i*x +: x]
//   res_out/res_err   product (2*x) and watchdog error flag, valid with ack
//   start/OpA/OpB     to the multiplier; operands held for the whole operation
//   busy/ready/mul    from the multiplier
//
// state     | meaning
// IDLE      | waiting for any req; grants round-robin and latches operands
// START     | start pulse to the multiplier
// WAIT_BUSY | waiting for busy (or an immediate ready from a fast multiplier)
// WAIT_RDY  | waiting for ready with busy low
// DONE      | ack pulse to the served requester, advance rr_ptr
module mul_share_arbiter
    import mul_share_pkg::*;
#(
    parameter int x   = 8,
    parameter int N   = 4,
    parameter int TMO = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*x-1:0]   opa_in,
    input  logic [N*x-1:0]   opb_in,
    output logic [N-1:0]     ack,
    output logic [2*x-1:0]   res_out,
    output logic             res_err,
    output logic             start,
    output logic [x-1:0]     OpA,
    output logic [x-1:0]     OpB,
    input  logic             busy,
    input  logic             ready,
    input  logic [2*x-1:0]   mul
);

    localparam int ID_W = id_w(N);
    localparam int WD_W = tmo_w(TMO);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TMO);
    localparam logic [N-1:0]    ONE_HOT = N'(1);

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] id;
    logic [WD_W-1:0] wd;
    logic            gnt_vld;
    logic [ID_W-1:0] gnt_id;
    logic [x-1:0]    sel_a;
    logic [x-1:0]    sel_b;

    rr_pick #(.N(N)) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr),
        .gnt_vld (gnt_vld),
        .gnt_id  (gnt_id)
    );

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt_id == ID_W'(i)) begin
                sel_a = opa_in[i*x +: x];
                sel_b = opb_in[i*x +: x];
            end
        end
    end

    // Watchdog is a down-counter loaded with TMO on entry to each wait
    // state; terminal count 0 means TMO cycles have elapsed there.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            id      <= '0;
            wd      <= '0;
            start   <= 1'b0;
            ack     <= '0;
            res_out <= '0;
            res_err <= 1'b0;
            OpA     <= '0;
            OpB     <= '0;
        end else begin
            start <= 1'b0;
            ack   <= '0;
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        id    <= gnt_id;
                        OpA   <= sel_a;
                        OpB   <= sel_b;
                        start <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    wd    <= WD_LOAD;
                    state <= WAIT_BUSY;
                end
                WAIT_BUSY: begin
                    if (busy) begin
                        wd    <= WD_LOAD;
                        state <= WAIT_RDY;
                    end else if (ready) begin
                        res_out <= mul;
                        res_err <= 1'b0;
                        ack     <= ONE_HOT << id;
                        state   <= DONE;
                    end else if (wd == '0) begin
                        res_out <= '0;
                        res_err <= 1'b1;
                        ack     <= ONE_HOT << id;
                        state   <= DONE;
                    end else begin
                        wd <= wd - 1'b1;
                    end
                end
                WAIT_RDY: begin
                    if (ready && !busy) begin
                        res_out <= mul;
                        res_err <= 1'b0;
                        ack     <= ONE_HOT << id;
                        state   <= DONE;
                    end else if (wd == '0) begin
                        res_out <= '0;
                        res_err <= 1'b1;
                        ack     <= ONE_HOT << id;
                        state   <= DONE;
                    end else begin
                        wd <= wd - 1'b1;
                    end
                end
                DONE: begin
                    rr_ptr <= (int'(id) == N - 1) ? '0 : id + 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_arbiter.sv
module tb_mul_share_arbiter;

    localparam int X   = 8;
    localparam int N   = 4;
    localparam int TMO = 64;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [N-1:0]     req = '0;
    logic [N*X-1:0]   opa_in = '0;
    logic [N*X-1:0]   opb_in = '0;
    logic [N-1:0]     ack;
    logic [2*X-1:0]   res_out;
    logic             res_err;
    logic             start;
    logic [X-1:0]     OpA;
    logic [X-1:0]     OpB;
    logic             busy;
    logic             ready;
    logic [2*X-1:0]   mul;

    int tests = 0;
    int fails = 0;
    int mul_mode = 0;     // 0: shift-add, 1: fast (ready without busy), 2: stuck
    int start_cnt = 0;
    int rr_model = 0;

    typedef struct { int id; logic [X-1:0] a; logic [X-1:0] b; } op_t;
    typedef struct { int id; logic [2*X-1:0] res; logic err; } exp_t;

    op_t  opq[$];         // operands each requester still has to present
    op_t  mdl[$];         // reference model's view of outstanding work
    exp_t sb_q[$];        // expected acks in service order

    mul_share_arbiter #(.x(X), .N(N), .TMO(TMO)) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .opa_in  (opa_in),
        .opb_in  (opb_in),
        .ack     (ack),
        .res_out (res_out),
        .res_err (res_err),
        .start   (start),
        .OpA     (OpA),
        .OpB     (OpB),
        .busy    (busy),
        .ready   (ready),
        .mul     (mul)
    );

    always #5 clk = ~clk;

    // Sequential shift-add multiplier sharing the arbiter's reset.
    logic [X-1:0]   m_a, m_b;
    logic [2*X-1:0] m_acc, pp;
    logic [3:0]     m_cnt;
    assign pp = m_b[m_cnt[2:0]] ? ((2*X)'(m_a) << m_cnt) : '0;

    always @(posedge clk) begin
        if (reset) begin
            busy <= 1'b0; ready <= 1'b0; mul <= '0;
            m_a <= '0; m_b <= '0; m_acc <= '0; m_cnt <= '0;
        end else if (start) begin
            m_a <= OpA; m_b <= OpB; m_acc <= '0; m_cnt <= '0;
            if (mul_mode == 2) begin
                busy <= 1'b0; ready <= 1'b0;
            end else if (mul_mode == 1) begin
                busy <= 1'b0; ready <= 1'b1; mul <= (2*X)'(OpA) * (2*X)'(OpB);
            end else begin
                busy <= 1'b1; ready <= 1'b0;
            end
        end else if (busy) begin
            if (m_cnt == 4'(X - 1)) begin
                busy <= 1'b0; ready <= 1'b1; mul <= m_acc + pp;
            end else begin
                m_acc <= m_acc + pp; m_cnt <= m_cnt + 1'b1;
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp_v);
        end
    endtask

    function automatic int find_op(input int id);
        int k;
        k = -1;
        for (int j = 0; j < opq.size(); j++)
            if (k < 0 && opq[j].id == id) k = j;
        return k;
    endfunction

    task automatic load(input int i);
        int k;
        k = find_op(i);
        if (k >= 0) begin
            opa_in[i*X +: X] = opq[k].a;
            opb_in[i*X +: X] = opq[k].b;
            req[i] = 1'b1;
        end
    endtask

    task automatic add_op(input int i, input logic [X-1:0] a, input logic [X-1:0] b);
        op_t o;
        o.id = i; o.a = a; o.b = b;
        opq.push_back(o);
        mdl.push_back(o);
    endtask

    // Reference: serve outstanding work one at a time, always taking the
    // next requester (cyclically) after the one served last.
    task automatic launch(input logic [N-1:0] mask);
        int cur, found;
        op_t o;
        exp_t e;
        cur = rr_model;
        while (mdl.size() > 0) begin
            found = -1;
            for (int k = 0; k < mdl.size(); k++)
                if (found < 0 && mdl[k].id == cur) found = k;
            if (found >= 0) begin
                o = mdl[found];
                mdl.delete(found);
                e.id  = o.id;
                e.err = (mul_mode == 2);
                e.res = e.err ? '0 : (2*X)'(o.a) * (2*X)'(o.b);
                sb_q.push_back(e);
                rr_model = (cur + 1) % N;
            end
            cur = (cur + 1) % N;
        end
        for (int i = 0; i < N; i++)
            if (mask[i] && !req[i]) load(i);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_all();
        sb_q.delete(); opq.delete(); mdl.delete();
        req = '0;
        rr_model = 0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((sb_q.size() > 0 || req != '0) && n < 3000) begin
            step();
            n++;
        end
        tests++;
        if (sb_q.size() > 0 || req != '0) begin
            fails++;
            $display("FAIL %s_timeout: got %0d acks outstanding, req=%b; required all served", nm, sb_q.size(), req);
            clear_all();
            reset = 1'b1; step(); step(); reset = 1'b0;
        end
        step(); step();
    endtask

    task automatic wait_start(input int s0, input string nm);
        int n;
        n = 0;
        while (start_cnt == s0 && n < 100) begin step(); n++; end
        check({nm, "_start_seen"}, 32'(start_cnt != s0), 32'd1);
    endtask

    // Monitor, requester agents, and post-grant operand scrambling.
    always @(negedge clk) begin
        exp_t e;
        int gid, k;
        if (!reset) begin
            if (start) begin
                start_cnt++;
                if (sb_q.size() > 0) begin
                    opa_in[sb_q[0].id*X +: X] = X'($urandom);
                    opb_in[sb_q[0].id*X +: X] = X'($urandom);
                end
            end
            if (ack != '0) begin
                gid = 0;
                for (int i = 0; i < N; i++) if (ack[i]) gid = i;
                if ($countones(ack) != 1 || sb_q.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_ack: got ack=%b with %0d queued, required one-hot ack of a queued request", ack, sb_q.size());
                end else begin
                    e = sb_q.pop_front();
                    check("ack_id", gid, e.id);
                    check("res_out", 32'(res_out), 32'(e.res));
                    check("res_err", 32'(res_err), 32'(e.err));
                end
                for (int i = 0; i < N; i++) begin
                    if (ack[i]) begin
                        k = find_op(i);
                        if (k >= 0) opq.delete(k);
                        if (find_op(i) >= 0) load(i);
                        else req[i] = 1'b0;
                    end
                end
            end
        end
    end

    function automatic logic [X-1:0] rand_op();
        int r;
        r = $urandom_range(0, 7);
        if (r == 0) return '0;
        if (r == 1) return '1;
        return X'($urandom);
    endfunction

    initial begin
        int s0, n, got, cnt;
        logic [N-1:0] mask;

        repeat (3) @(negedge clk);
        #1;
        check("rst_ack", 32'(ack), 0);
        check("rst_start", 32'(start), 0);
        check("rst_res_out", 32'(res_out), 0);
        check("rst_res_err", 32'(res_err), 0);
        check("rst_opa", 32'(OpA), 0);
        check("rst_opb", 32'(OpB), 0);
        reset = 1'b0;
        step();

        // Contention from reset: order 0,1,2,3.
        add_op(0, 8'd3, 8'd5); add_op(1, 8'd7, 8'd11);
        add_op(2, 8'd13, 8'd17); add_op(3, 8'd19, 8'd23);
        launch(4'b1111);
        wait_idle("contention");

        // Fairness and wrap: req0 held for two ops, req3 raised during op0.
        add_op(0, 8'd40, 8'd2); add_op(0, 8'd41, 8'd3); add_op(3, 8'd99, 8'd4);
        s0 = start_cnt;
        launch(4'b0001);
        wait_start(s0, "fair");
        load(3);
        wait_idle("fairness");

        // Single request; req2 pulsed mid-operation must be ignored.
        s0 = start_cnt;
        add_op(0, 8'd12, 8'd13);
        launch(4'b0001);
        wait_start(s0, "single");
        req[2] = 1'b1; step(); step(); req[2] = 1'b0;
        wait_idle("single");
        check("single_start_pulses", start_cnt - s0, 1);

        // Extreme operands.
        add_op(1, 8'd255, 8'd255); add_op(2, 8'd0, 8'd200);
        launch(4'b0110);
        wait_idle("extreme");

        // Randomized batches, some with a fast multiplier.
        for (int b = 0; b < 25; b++) begin
            mul_mode = ($urandom_range(0, 3) == 0) ? 1 : 0;
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int i = 0; i < N; i++) begin
                if (mask[i]) begin
                    cnt = $urandom_range(1, 2);
                    for (int c = 0; c < cnt; c++) add_op(i, rand_op(), rand_op());
                end
            end
            launch(mask);
            wait_idle("random");
        end
        mul_mode = 0;

        // Watchdog: multiplier never responds.
        mul_mode = 2;
        add_op(1, 8'd9, 8'd11);
        launch(4'b0010);
        n = 0; got = 0;
        while (got == 0 && n < TMO + 20) begin
            @(posedge clk); #1;
            n++;
            if (ack[1]) got = 1;
        end
        check("wdog_latency", (got != 0) ? n : -1, TMO + 3);
        wait_idle("wdog");
        mul_mode = 0;
        add_op(1, 8'd21, 8'd3);
        launch(4'b0010);
        wait_idle("after_wdog");

        // Reset while waiting for ready.
        add_op(1, 8'hA5, 8'h3C);
        launch(4'b0010);
        n = 0;
        while (!busy && n < 50) begin step(); n++; end
        check("rst_mid_busy_seen", 32'(busy), 1);
        step();
        reset = 1'b1;
        clear_all();
        @(posedge clk); #1;
        check("rst_mid_start", 32'(start), 0);
        check("rst_mid_ack", 32'(ack), 0);
        check("rst_mid_opa", 32'(OpA), 0);
        check("rst_mid_opb", 32'(OpB), 0);
        check("rst_mid_res_out", 32'(res_out), 0);
        step();
        reset = 1'b0;
        step();
        add_op(2, 8'd77, 8'd91);
        launch(4'b0100);
        wait_idle("after_reset");

        check("sb_drained", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no completion, required finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
